lfsr_rr_ctrl: RTL and testbench

Controller that shares one internal Galois LFSR between two requesters using round-robin arbitration.
- On each accepted request the LFSR advances STEPS times, then the resulting word is delivered to the granted requester with a one-cycle grant pulse.
- Also handles seed loading with zero-lockup protection.
- Sits between the pseudo-random source and its consumers (test-pattern and scrambler clients).

---
 rtl/lfsr_rr_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lfsr_rr_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_ctrl.sv
// rtl/lfsr_rr_ctrl.sv - shared Galois LFSR served round-robin to two requesters (optional LFSR_GRANT_CNT_EN grant counters)
//
// A request is accepted in IDLE. The LFSR then advances STEPS times in RUN.
// The last step's value is delivered with a one-cycle gnt/rnd_valid pulse.
// DONE is a single turnaround cycle before IDLE.
// Defining LFSR_GRANT_CNT_EN adds saturating 8-bit per-requester grant counters.
module lfsr_rr_ctrl #(
    parameter int                  BITWIDTH = 5,
    parameter logic [BITWIDTH-1:0] TAPS     = 5'b10100,
    parameter int                  STEPS    = 5,
    parameter logic [BITWIDTH-1:0] SEED     = {{(BITWIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                seed_load,
    input  logic [BITWIDTH-1:0] seed_in,
    input  logic [1:0]          req,
    output logic [1:0]          gnt,
    output logic [BITWIDTH-1:0] rnd_out,
    output logic                rnd_valid,
`ifdef LFSR_GRANT_CNT_EN
    output logic [7:0]          gnt_cnt0,
    output logic [7:0]          gnt_cnt1,
`endif
    output logic                busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BITWIDTH-1:0] STEPS_W = BITWIDTH'(STEPS);
    localparam logic [BITWIDTH-1:0] CNT_ONE = BITWIDTH'(1);

    logic [1:0]          state_q, state_d;
    logic [BITWIDTH-1:0] lfsr_q, lfsr_d;
    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                ptr_q, ptr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic [BITWIDTH-1:0] rnd_q, rnd_d;
    logic                busy_q, busy_d;

    logic [BITWIDTH-1:0] lfsr_next;
    logic                seed_honoured;
    logic                pick;

    // One Galois step: shift right, fold the taps back in when a one falls out
    always_comb begin
        lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end

    // Owner choice: a lone request wins outright; on a tie the side that was not served last wins
    always_comb begin
        if (req == 2'b11) begin
            pick = ~ptr_q;
        end else begin
            pick = req[1];
        end
    end

    // Controller next-state: seed handling, acceptance, stepping and delivery
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        gnt_d         = 2'b00;
        valid_d       = 1'b0;
        rnd_d         = rnd_q;
        seed_honoured = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    // A zero seed would lock the LFSR at zero forever
                    lfsr_d        = (seed_in == '0) ? SEED : seed_in;
                    seed_honoured = 1'b1;
                end else if (req != 2'b00) begin
                    owner_d = pick;
                    cnt_d   = STEPS_W;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                lfsr_d = lfsr_next;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    rnd_d   = lfsr_next;
                    valid_d = 1'b1;
                    gnt_d   = owner_q ? 2'b10 : 2'b01;
                    ptr_d   = owner_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            ptr_q   <= 1'b1;
            gnt_q   <= 2'b00;
            valid_q <= 1'b0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_out   = rnd_q;
    assign rnd_valid = valid_q;
    assign busy      = busy_q;

`ifdef LFSR_GRANT_CNT_EN
    logic [7:0] gcnt0_q, gcnt0_d;
    logic [7:0] gcnt1_q, gcnt1_d;

    // Saturating grant tallies, cleared whenever a seed load is taken
    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (seed_honoured) begin
            gcnt0_d = '0;
            gcnt1_d = '0;
        end else begin
            if (gnt_d[0] && (gcnt0_q != 8'hFF)) begin
                gcnt0_d = gcnt0_q + 8'd1;
            end
            if (gnt_d[1] && (gcnt1_q != 8'hFF)) begin
                gcnt1_d = gcnt1_q + 8'd1;
            end
        end
    end

    // Grant counter registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign gnt_cnt0 = gcnt0_q;
    assign gnt_cnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_lfsr_rr_ctrl.sv
// tb/tb_lfsr_rr_ctrl.sv - directed self-checking bench for lfsr_rr_ctrl
module tb_lfsr_rr_ctrl;

    logic       clk;
    logic       arst;
    logic       seed_load;
    logic [4:0] seed_in;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [4:0] rnd_out;
    logic       rnd_valid;
    logic       busy;
`ifdef LFSR_GRANT_CNT_EN
    logic [7:0] gnt_cnt0;
    logic [7:0] gnt_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    lfsr_rr_ctrl dut (
        .clk       (clk),
        .arst      (arst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .gnt       (gnt),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
`ifdef LFSR_GRANT_CNT_EN
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step negedges until rnd_valid is seen, bounded; cyc is the number of negedges taken
    task automatic wait_valid(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!rnd_valid && c < 20);
    endtask

    initial begin
        arst      = 1'b1;
        seed_load = 1'b0;
        seed_in   = 5'd0;
        req       = 2'b00;
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_valid", rnd_valid, 1'b0);
        chk("rst_rnd", rnd_out, 5'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lfsr", dut.lfsr_q, 5'h01);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);

        // Single requester from reset seed: 1->20->10->5->22->11
        req = 2'b01;
        @(negedge clk);
        chk("t1_busy_run", busy, 1'b1);
        chk("t1_gnt_run", gnt, 2'b00);
        wait_valid(cyc);
        chk("t1_latency", cyc, 5);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_rnd", rnd_out, 5'h0B);
        chk("t1_busy_done", busy, 1'b1);
        req = 2'b00;
        @(negedge clk);
        chk("t1_gnt_clr", gnt, 2'b00);
        chk("t1_valid_clr", rnd_valid, 1'b0);
        chk("t1_busy_idle", busy, 1'b0);
        chk("t1_rnd_hold", rnd_out, 5'h0B);

        // Both requesters held: grants 1,0,1 each STEPS+2 cycles apart
        req = 2'b11;
        wait_valid(cyc);
        chk("t2_lat_a", cyc, 6);
        chk("t2_gnt_a", gnt, 2'b10);
        chk("t2_rnd_a", rnd_out, 5'h17);
        wait_valid(cyc);
        chk("t2_period_b", cyc, 7);
        chk("t2_gnt_b", gnt, 2'b01);
        chk("t2_rnd_b", rnd_out, 5'h0C);
        wait_valid(cyc);
        chk("t2_period_c", cyc, 7);
        chk("t2_gnt_c", gnt, 2'b10);
        chk("t2_rnd_c", rnd_out, 5'h0F);
        req = 2'b00;
        @(negedge clk);
        chk("t2_busy_idle", busy, 1'b0);

        // Zero seed is replaced by SEED
        seed_load = 1'b1;
        seed_in   = 5'd0;
        @(negedge clk);
        chk("t3_lfsr_sub", dut.lfsr_q, 5'h01);
        seed_load = 1'b0;
        req       = 2'b01;
        wait_valid(cyc);
        chk("t3_gnt", gnt, 2'b01);
        chk("t3_rnd", rnd_out, 5'h0B);
        req = 2'b00;
        @(negedge clk);

        // Seed load wins over a simultaneous request; request taken next cycle
        seed_load = 1'b1;
        seed_in   = 5'd5;
        req       = 2'b10;
        @(negedge clk);
        chk("t4_no_accept", busy, 1'b0);
        chk("t4_lfsr_seed", dut.lfsr_q, 5'h05);
        seed_load = 1'b0;
        wait_valid(cyc);
        chk("t4_latency", cyc, 6);
        chk("t4_gnt", gnt, 2'b10);
        chk("t4_rnd", rnd_out, 5'h0E);
        req = 2'b00;
        @(negedge clk);

        // Reset three cycles into RUN, then a tie after reset goes to requester 0
        req = 2'b01;
        repeat (3) @(negedge clk);
        chk("t5_busy_pre", busy, 1'b1);
        arst = 1'b1;
        #1;
        chk("t5_gnt", gnt, 2'b00);
        chk("t5_valid", rnd_valid, 1'b0);
        chk("t5_rnd", rnd_out, 5'h00);
        chk("t5_busy", busy, 1'b0);
        chk("t5_lfsr", dut.lfsr_q, 5'h01);
        @(negedge clk);
        arst = 1'b0;
        req  = 2'b11;
        wait_valid(cyc);
        chk("t5_re_gnt", gnt, 2'b01);
        chk("t5_re_rnd", rnd_out, 5'h0B);
        req = 2'b00;
        @(negedge clk);

        // req dropped and seed_load raised during RUN/DONE: both ignored
        req = 2'b01;
        @(negedge clk);
        req       = 2'b00;
        seed_load = 1'b1;
        seed_in   = 5'd7;
        wait_valid(cyc);
        chk("t6_gnt", gnt, 2'b01);
        chk("t6_rnd", rnd_out, 5'h17);
        @(negedge clk);
        seed_load = 1'b0;
        chk("t6_lfsr_kept", dut.lfsr_q, 5'h17);
        req = 2'b01;
        wait_valid(cyc);
        chk("t6_next_rnd", rnd_out, 5'h0C);
        req = 2'b00;
        @(negedge clk);

`ifdef LFSR_GRANT_CNT_EN
        // Counter saturation and clear on an honoured seed load
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        chk("t7_cnt0_rst", gnt_cnt0, 8'd0);
        req = 2'b01;
        for (int g = 0; g < 300; g++) begin
            wait_valid(cyc);
        end
        req = 2'b00;
        @(negedge clk);
        chk("t7_cnt0_sat", gnt_cnt0, 8'd255);
        chk("t7_cnt1_zero", gnt_cnt1, 8'd0);
        seed_load = 1'b1;
        seed_in   = 5'd3;
        @(negedge clk);
        seed_load = 1'b0;
        chk("t7_cnt0_clr", gnt_cnt0, 8'd0);
        chk("t7_cnt1_clr", gnt_cnt1, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
